// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI request/response types shared by masters, slaves and the arbiter.
package obi_pkg;

  localparam int OBI_ADDR_W          = 32;
  localparam int OBI_DATA_W          = 32;
  localparam int OBI_ARB_MAX_MASTERS = 4;

  typedef struct packed {
    logic                    req;
    logic                    we;
    logic [OBI_DATA_W/8-1:0] be;
    logic [OBI_ADDR_W-1:0]   addr;
    logic [OBI_DATA_W-1:0]   wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// rtl/obi_arb_id_fifo.sv - in-order FIFO of granted master IDs awaiting their response.
module obi_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // full/empty come from the registered count, so a pop never frees a slot in the same cycle
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// rtl/obi_rr_arbiter.sv - round-robin arbiter sharing one OBI slave port among several masters.
module obi_rr_arbiter
  import obi_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2,
  localparam int IW             = $clog2(NUM_MASTERS),
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  m_req_i  [NUM_MASTERS],
  output obi_resp_t m_resp_o [NUM_MASTERS],
  output obi_req_t  s_req_o,
  input  obi_resp_t s_resp_i,
  output logic [CW-1:0] outstanding_o,
  output logic      err_o
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]    state_q;
  logic [IW-1:0] last_q, sel_q, rr_idx, sel, fifo_head;
  logic          rr_found, sel_valid, granted, fifo_full, fifo_empty, err_q;
  int            cand;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = (int'(last_q) + i) % NUM_MASTERS;
      if (!rr_found && m_req_i[cand].req) begin
        rr_found = 1'b1;
        rr_idx   = IW'(cand);
      end
    end
  end

  assign sel       = (state_q == LOCKED) ? sel_q : rr_idx;
  assign sel_valid = (state_q == LOCKED) || rr_found;

  always_comb begin
    s_req_o = '0;
    if (sel_valid) begin
      s_req_o     = m_req_i[sel];
      s_req_o.req = m_req_i[sel].req && !fifo_full;
    end
  end

  assign granted = s_resp_i.gnt && s_req_o.req;

  // rvalid follows the registered FIFO head, keeping gnt and rvalid paths independent
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_resp_o[i].gnt    = granted && (sel == IW'(i));
      m_resp_o[i].rvalid = s_resp_i.rvalid && !fifo_empty && (fifo_head == IW'(i));
      m_resp_o[i].rdata  = s_resp_i.rdata;
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_id_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (granted),
    .push_data (sel),
    .pop       (s_resp_i.rvalid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      err_q   <= 1'b0;
    end else begin
      if (granted) last_q <= sel;
      if (s_resp_i.rvalid && fifo_empty) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (s_req_o.req && !s_resp_i.gnt) begin
            state_q <= LOCKED;
            sel_q   <= sel;
          end
        end
        default: begin
          if (granted) state_q <= IDLE;
        end
      endcase
    end
  end

  assign err_o = err_q;

endmodule
